instr_loader: RTL
=================

// Module: instr_loader
// PURPOSE
// - Byte-stream program loader: the write-side counterpart of the instruction ROM's read port.
// - Sits between a UART byte receiver and the instruction memory write port.
// - Assembles little-endian 32-bit words and writes them from word 0 upward.
// - Holds the core in reset until the whole program is loaded.
// PARAMETERS
// - MEM_SIZE_WORDS  1024  capacity of instruction memory in 32-bit words (equals memory_pkg::INSTR_MEM_SIZE_WORDS)
// PORTS
// - clk_i          in   1   system clock
// - rst_i          in   1   synchronous, active-high reset
// - rx_valid_i     in   1   rx_data_i holds a new byte this cycle; one-cycle strobe, back-to-back allowed
// - rx_data_i      in   8   received byte
// - mem_we_o       out  1   write strobe to instruction memory, one cycle per word
// - mem_addr_o     out  32  byte address of the write, always word-aligned (4*word index)
// - mem_wdata_o    out  32  word to write
// - core_rst_o     out  1   reset to the processor core; 1 until load completes
// - done_o         out  1   load completed successfully
// - err_o          out  1   header word count exceeded MEM_SIZE_WORDS
// BEHAVIOUR
// - Clock and reset: one clock, clk_i; reset is synchronous and active-high (rst_i).
// - Reset values: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_o=1, done_o=0, err_o=0.
//   Internal state is LEN, and the byte and word counters are 0.
// - Stream format:
//   - Bytes 0..3: word count N, little-endian.
//   - Then N*4 program bytes; each word is little-endian (first byte -> bits [7:0]).
// - Byte acceptance: exactly one byte per cycle in which rx_valid_i=1. No backpressure exists.
// - State LEN: collects 4 header bytes. On the 4th byte:
//   - N==0 -> DONE
//   - N>MEM_SIZE_WORDS -> ERR
//   - otherwise -> DATA
//   - Transition takes effect the cycle after the 4th byte.
// - State DATA: collects bytes into the word shift register.
//   - On the 4th byte of word k (valid in cycle T), cycle T+1 presents:
//     mem_we_o=1, mem_addr_o=4*k, mem_wdata_o=assembled word.
//   - mem_we_o is 1 for exactly one cycle per word.
//   - mem_addr_o/mem_wdata_o hold their last values afterwards.
//   - A byte arriving in the same cycle as a write pulse is accepted normally; no bytes are lost at full rate.
//   - After word N-1 is written: state DONE is entered in T+1 (the write cycle).
//     core_rst_o=0 and done_o=1 from cycle T+2.
// - State DONE: core_rst_o=0, done_o=1, mem_we_o=0. All further bytes are ignored. Exit only via rst_i.
// - State ERR: err_o=1, core_rst_o=1, mem_we_o=0. No memory writes occur. Bytes are ignored. Exit only via rst_i.
// - N==MEM_SIZE_WORDS is legal; last address written = 4*(MEM_SIZE_WORDS-1).
// - The word counter is wide enough for MEM_SIZE_WORDS and never wraps.
// - Header count is compared at full 32-bit width; no truncation.
// - Reset mid-load: the next cycle returns to LEN with all outputs at reset values.
//   - A partially assembled word is discarded.
//   - Memory words already written are not cleared.
// - A partial stream that stalls forever leaves the loader in LEN/DATA with core_rst_o=1. There is no timeout.
// TESTING
// - N=2 (bytes 02 00 00 00), then 13 05 00 00, 93 05 10 00
//   -> two pulses: addr 0 data 0x00000513, addr 4 data 0x00100593.
//   -> core_rst_o falls 2 cycles after the last byte; done_o=1.
// - N=0 (00 00 00 00) -> no mem_we_o pulse; done_o=1 and core_rst_o=0 from 2 cycles after the 4th byte.
// - N=MEM_SIZE_WORDS+1 -> err_o=1, core_rst_o stays 1.
//   Zero write pulses even after 8 further bytes.
// - N=3 sent with rx_valid_i high every cycle -> write pulses exactly 4 cycles apart.
//   Addresses 0, 4, 8, with correct data.
// - rst_i asserted after 6 program bytes of N=4, then a full N=1 stream with word 0xDEADBEEF
//   -> single write: addr 0 data 0xDEADBEEF, then done_o=1.
// - Extra bytes after DONE -> no writes; done_o and core_rst_o unchanged.

Source files
------------

// File: rtl/instr_loader.sv
// Byte-stream program loader: assembles little-endian words from a UART
// byte stream, writes them to instruction memory, and holds the core in reset.
module instr_loader #(
    parameter int unsigned MEM_SIZE_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int CW = $clog2(MEM_SIZE_WORDS + 1);

    typedef enum logic [1:0] {
        LEN,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    byte_cnt;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] n_words;
    logic [31:0]   shreg;
    logic [31:0]   word_nxt;
    logic          loading;
    logic          last_byte;
    logic          word_fire;
    logic          last_word;

    // First byte ends up in [7:0] after four right shifts.
    assign word_nxt  = {rx_data_i, shreg[31:8]};
    assign loading   = (state == LEN) || (state == DATA);
    assign last_byte = rx_valid_i && (byte_cnt == 2'd3);
    assign word_fire = (state == DATA) && last_byte;
    assign last_word = word_fire && (word_cnt == n_words - CW'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= LEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LEN: begin
                if (last_byte) begin
                    if (word_nxt == 32'd0) begin
                        state_nxt = DONE;
                    end else if (word_nxt > 32'(MEM_SIZE_WORDS)) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = DONE;
            ERR:  state_nxt = ERR;
            default: state_nxt = LEN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_cnt    <= 2'd0;
            word_cnt    <= '0;
            n_words     <= '0;
            shreg       <= 32'd0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            core_rst_o  <= 1'b1;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            mem_we_o   <= word_fire;
            core_rst_o <= (state != DONE);
            done_o     <= (state == DONE);
            err_o      <= (state == ERR);
            if (rx_valid_i && loading) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= word_nxt;
            end
            if ((state == LEN) && last_byte) begin
                n_words <= word_nxt[CW-1:0];
            end
            if (word_fire) begin
                word_cnt    <= word_cnt + CW'(1);
                mem_addr_o  <= 32'({word_cnt, 2'b00});
                mem_wdata_o <= word_nxt;
            end
        end
    end

endmodule
